// File: rtl/tdpram_port_ctrl.sv
// tdpram_port_ctrl
// Flow-controlled initiator for one port of the true dual-port RAM wrapper.
// Requests (read or write) are handed straight to the RAM port with no added
// latency. Read data returning after the fixed RAM latency is captured into a
// small first-word-fall-through FIFO and handed out in request order on a
// valid/ready response channel. A credit counter covers reads in flight plus
// buffered responses, so the FIFO can never overflow.
//
// Parameter constraints (not checked in hardware):
//   RD_LATENCY must be 1..8 and equal to the RAM's configured read latency.
//   RSP_DEPTH must be >= 1; use RD_LATENCY+1 or more for full read throughput.
module tdpram_port_ctrl #(
    parameter int DAT_WDH    = 32,
    parameter int ADR_WDH    = 6,
    parameter int RD_LATENCY = 2,
    parameter int RSP_DEPTH  = 4
) (
    input  logic               clk,
    input  logic               rst,

    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_we,
    input  logic [ADR_WDH-1:0] req_addr,
    input  logic [DAT_WDH-1:0] req_wdata,

    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [DAT_WDH-1:0] rsp_rdata,

    output logic               ram_en,
    output logic               ram_we,
    output logic [ADR_WDH-1:0] ram_addr,
    output logic [DAT_WDH-1:0] ram_din,
    input  logic [DAT_WDH-1:0] ram_dout,

    output logic               busy
);

    localparam int CNT_WDH = $clog2(RSP_DEPTH + 1);
    localparam int PTR_WDH = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;

    localparam logic [CNT_WDH-1:0] DEPTH_C  = CNT_WDH'(RSP_DEPTH);
    localparam logic [CNT_WDH-1:0] CNT_ONE  = CNT_WDH'(1);
    localparam logic [PTR_WDH-1:0] PTR_LAST = PTR_WDH'(RSP_DEPTH - 1);
    localparam logic [PTR_WDH-1:0] PTR_ONE  = PTR_WDH'(1);

    // Credits: reads in flight plus responses still sitting in the FIFO.
    logic [CNT_WDH-1:0]    r_cnt;
    // Read-valid pipeline tracking the RAM's read latency.
    logic [RD_LATENCY-1:0] r_pipe;
    // Response FIFO storage and bookkeeping.
    logic [DAT_WDH-1:0]    r_mem [RSP_DEPTH];
    logic [PTR_WDH-1:0]    r_wptr;
    logic [PTR_WDH-1:0]    r_rptr;
    logic [CNT_WDH-1:0]    r_fill;

    logic w_accept;
    logic w_rd_acc;
    logic w_push;
    logic w_pop;
    logic w_empty;
    logic w_full;

    // Pointers wrap by compare-and-clear so any depth works, not just powers of two.
    function automatic logic [PTR_WDH-1:0] ptrInc(input logic [PTR_WDH-1:0] p);
        return (p == PTR_LAST) ? '0 : (p + PTR_ONE);
    endfunction

    // Ready depends only on credits, never on req_valid; writes stall too when
    // credits are gone, which keeps the request path strictly in order.
    assign req_ready = !rst && (r_cnt < DEPTH_C);
    assign w_accept  = req_valid && req_ready;
    assign w_rd_acc  = w_accept && !req_we;

    // RAM port is a pure pass-through of the accepted request.
    assign ram_en    = w_accept;
    assign ram_we    = w_accept && req_we;
    assign ram_addr  = req_addr;
    assign ram_din   = req_wdata;

    // The tail of the valid pipeline lines up with ram_dout for that read.
    assign w_push    = r_pipe[RD_LATENCY-1];

    assign w_empty   = (r_fill == '0);
    assign w_full    = (r_fill == DEPTH_C);

    // Response side is forced quiet while reset is held so nothing leaks out.
    assign rsp_valid = !rst && !w_empty;
    assign rsp_rdata = rsp_valid ? r_mem[r_rptr] : '0;
    assign w_pop     = rsp_valid && rsp_ready;

    assign busy      = (r_cnt != '0);

    // Credit counter: take one per accepted read, return one per response pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case ({w_rd_acc, w_pop})
                2'b10:   r_cnt <= r_cnt + CNT_ONE;
                2'b01:   r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // Shift read-valid bits along so the tail fires when the RAM data is ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_rd_acc;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    // FIFO pointers and fill level; push and pop in one cycle are both honoured.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_fill <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= ptrInc(r_wptr);
            end
            if (w_pop) begin
                r_rptr <= ptrInc(r_rptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + CNT_ONE;
                2'b01:   r_fill <= r_fill - CNT_ONE;
                default: r_fill <= r_fill;
            endcase
        end
    end

    // Capture returning RAM data; storage itself needs no reset because
    // rsp_rdata is masked whenever the FIFO is empty.
    always_ff @(posedge clk) begin
        if (!rst && w_push) begin
            r_mem[r_wptr] <= ram_dout;
        end
    end

    // Credits guarantee a free slot for every read in flight; a push into a
    // full FIFO would mean the credit accounting is broken.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(w_push && w_full));
        end
    end

endmodule

// File: doc/tdpram_port_ctrl.md
Name: tdpram_port_ctrl

Overview:
- Initiator-side controller for one port of the team's true dual-port RAM wrapper.
- Accepts valid/ready read and write requests and drives the RAM port enable, write enable, address and data.
- Tracks in-flight reads across the fixed RAM read latency and returns read data in order on a valid/ready response channel with backpressure.
- Used wherever datapath logic needs a flow-controlled view of a block RAM port. Two instances serve ports A and B.

Parameters:
- DAT_WDH, 32, data width; must match the RAM port width.
- ADR_WDH, 6, address width.
- RD_LATENCY, 2, RAM read latency in cycles; range 1..8; must equal the RAM's configured latency.
- RSP_DEPTH, 4, response FIFO depth; must be >= RD_LATENCY+1 for full read throughput; minimum 1.

Ports:
- clk  in  1  single clock; the RAM port is on the same clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when req_valid & req_ready.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADR_WDH  request address.
- req_wdata  in  DAT_WDH  write data.
- rsp_valid  out  1  read response valid.
- rsp_ready  in  1  response consumer ready.
- rsp_rdata  out  DAT_WDH  read data.
- ram_en  out  1  RAM port enable.
- ram_we  out  1  RAM port write enable.
- ram_addr  out  ADR_WDH  RAM address.
- ram_din  out  DAT_WDH  RAM write data.
- ram_dout  in  DAT_WDH  RAM read data.
- busy  out  1  high when any read is in flight or any response is unconsumed.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Credit counter cnt, width clog2(RSP_DEPTH+1), counts reads in flight plus FIFO entries.
  - +1 on each accepted read.
  - -1 on each response pop.
  - Both events in the same cycle: cnt unchanged.
- Ready rule: req_ready = !rst & (cnt < RSP_DEPTH). The rule applies to reads and writes alike, and req_ready does not depend on req_valid. A write is therefore stalled while credits are exhausted.
- RAM drive (combinational pass-through, zero added latency):
  - ram_en = req_valid & req_ready.
  - ram_we = ram_en & req_we.
  - ram_addr = req_addr; ram_din = req_wdata.
- Read pipeline: a RD_LATENCY-deep shift register of valid bits. Bit 0 is set on an accepted read in cycle T. At T+RD_LATENCY the tail bit is set, and ram_dout is pushed into the response FIFO that cycle.
- Response FIFO:
  - Synchronous, RSP_DEPTH entries, first-word-fall-through.
  - rsp_valid = FIFO not empty; rsp_rdata = head entry.
  - Pop on rsp_valid & rsp_ready.
  - Push and pop in the same cycle are both honoured, including at full and at empty+1.
  - With the FIFO empty, a pushed word appears on rsp_valid in the cycle after the push.
  - Total read latency, accept to rsp_valid, is RD_LATENCY+1 cycles.
- Ordering:
  - Responses are in strict request order.
  - Writes produce no response and consume no credit.
  - Write/read collision semantics are those of the RAM's write mode; this block adds no hazard logic.
- Overflow: impossible by construction. Assert in simulation that no push occurs when the FIFO is full; the assertion must never fire.
- Pointers: read and write pointers wrap modulo RSP_DEPTH. A non-power-of-two RSP_DEPTH is supported via explicit compare-and-clear.
- busy = (cnt != 0).
- Reset values: req_ready 0, ram_en 0, ram_we 0, rsp_valid 0, rsp_rdata 0, busy 0.
  - Pipeline bits, FIFO pointers and cnt are cleared.
  - A reset mid-operation discards in-flight reads and buffered responses. RAM data returning after reset is ignored.
  - req_ready rises in the first cycle after rst deasserts.

Test Plan:
- Reset then write addr 5 = 0xDEADBEEF, read addr 5, rsp_ready=1.
  -> ram_en/ram_we pulse on the write cycle; rsp_valid rises exactly RD_LATENCY+1 = 3 cycles after read accept, with rsp_rdata = 0xDEADBEEF.
- Back-to-back reads addr 0..7 (preloaded with value = addr*3), rsp_ready=1, RSP_DEPTH=4.
  -> req_ready stays 1; responses 0,3,...,21 in order, one per cycle.
- rsp_ready=0, issue 6 reads.
  -> exactly 4 accepted, then req_ready=0 and busy=1. Raise rsp_ready: 4 responses drain in order, req_ready returns to 1 in the cycle after the first pop.
- Credits exhausted (cnt=4) and a write is presented.
  -> the write is held (ram_en=0) until a pop, then issued.
- Assert rst for 1 cycle while 2 reads are in flight.
  -> rsp_valid stays 0 afterwards, cnt=0, busy=0, req_ready=1 in the first cycle after reset deasserts.
- Random mix of 1000 requests with random rsp_ready, checked against a reference memory model.
  -> every response matches, and there is no FIFO overflow assertion.
